icache_responder: RTL

//  Direct-mapped instruction cache that services the fetch stage. It answers
//  the fetch stage's PC lookup with the instruction and a hit flag (ins/hitt).
//  On a miss it refills the whole line from instruction memory via a req/valid

---
 rtl/icache_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//   Direct-mapped, read-only instruction cache between the fetch stage and
//   instruction memory. Hits are answered combinationally in the same cycle
//   as the lookup; a miss refills the whole line, one word per accepted
//   memory beat, then lookups resume against whatever pc_addr is presented.
//
// Ports
//   clkk        in   1       clock, rising edge
//   rstt        in   1       synchronous reset, active-high
//   pc_addr     in   ADDR_W  fetch byte address (bits [1:0] ignored)
//   fetch_req   in   1       fetch stage requests the word at pc_addr
//   ins         out  32      instruction word, 0 unless hitt=1
//   hitt        out  1       ins holds the word at pc_addr this cycle
//   mem_req     out  1       refill beat request
//   mem_addr    out  ADDR_W  word-aligned byte address of the requested beat
//   mem_rdata   in   32      refill data
//   mem_valid   in   1       beat for mem_addr is on mem_rdata this cycle
//
// States
//   ST_IDLE   | lookups active; a requested miss starts a refill
//   ST_REFILL | requesting beats of the latched line; lookups suppressed
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clkk,
  input  logic              rstt,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_req,
  output logic [31:0]       ins,
  output logic              hitt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  // Storage. Only the valid bits are reset; data and tags are don't-care
  // while their line is invalid.
  logic [31:0]      data_mem [LINES*WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  // Refill bookkeeping: the latched miss line (tag + index) and the beat
  // currently being requested.
  logic [0:0]       state_q;
  logic [OFF_W-1:0] beat_q;
  logic [TAG_W-1:0] rtag_q;
  logic [IDX_W-1:0] ridx_q;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             lookup_hit;
  logic             in_idle;
  logic             miss_start;
  logic             beat_accept;
  logic             last_beat;

  logic             unused_pc_lsb;

  assign pc_off = pc_addr[OFF_W+1:2];
  assign pc_idx = pc_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_tag = pc_addr[ADDR_W-1:IDX_W+OFF_W+2];

  // Byte-lane bits of the fetch address carry no information for a
  // word-granular cache.
  assign unused_pc_lsb = ^pc_addr[1:0];

  // ---------------------------------------------------------------------------
  // Lookup (zero latency). Gating with rstt keeps hitt/ins low for the whole
  // reset cycle even though the valid bits only clear on the edge.
  // ---------------------------------------------------------------------------
  assign in_idle    = (state_q == ST_IDLE) && !rstt;
  assign lookup_hit = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  always_comb begin
    hitt = in_idle && fetch_req && lookup_hit;
    ins  = '0;
    if (hitt) begin
      ins = data_mem[{pc_idx, pc_off}];
    end
  end

  assign miss_start = in_idle && fetch_req && !lookup_hit;

  // ---------------------------------------------------------------------------
  // Memory side. mem_req/mem_addr are decoded from registered state only, so
  // a stall (mem_valid low) leaves them untouched.
  // ---------------------------------------------------------------------------
  assign mem_req     = (state_q == ST_REFILL);
  assign mem_addr    = mem_req ? {rtag_q, ridx_q, beat_q, 2'b00} : '0;
  assign beat_accept = mem_req && mem_valid && !rstt;
  assign last_beat   = beat_accept && (beat_q == LAST_BEAT);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkk) begin
    if (rstt) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      rtag_q  <= '0;
      ridx_q  <= '0;
      valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_start) begin
            rtag_q  <= pc_tag;
            ridx_q  <= pc_idx;
            beat_q  <= '0;
            // The victim line is invalidated up front so an aborted refill
            // can never leave a partially written line looking valid.
            valid_q[pc_idx] <= 1'b0;
            state_q <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (mem_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              valid_q[ridx_q] <= 1'b1;
              state_q         <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data and tag arrays (no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkk) begin
    if (beat_accept) begin
      data_mem[{ridx_q, beat_q}] <= mem_rdata;
    end
    if (last_beat) begin
      tag_mem[ridx_q] <= rtag_q;
    end
  end

endmodule
